// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor
// Multi-cycle WIDTH-bit subtractor computing diff = a - b - b_in, DIGIT bits
// per clock through one ripple-borrow slice with a registered borrow between
// slices. Operands are exchanged through a start/busy/done handshake; the
// published results only change on the cycle done is high.
module serial_ripple_subtractor #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;         // minuend, shifted right one digit per slice
    logic [WIDTH-1:0] b_q, b_d;         // subtrahend, shifted right one digit per slice
    logic [WIDTH-1:0] res_q, res_d;     // partial difference, filled from the top
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    count_q, count_d;
    logic             a_msb_q, a_msb_d; // captured sign bits for the overflow term
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             b_out_q, b_out_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT:0]   slice;            // {borrow, digit} of the current slice
    logic             last_slice;

    // Ripple-borrow slice on the low digit of the shifted operands: the
    // (DIGIT+1)-bit result goes negative exactly when the slice borrows.
    always_comb begin
        slice      = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]}
                   - {{DIGIT{1'b0}}, borrow_q};
        last_slice = (count_q == CW'(N - 1));
    end

    // Next-state, datapath and result-load logic.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        count_d  = count_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        b_out_d  = b_out_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            RUN: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                res_d    = (res_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
                borrow_d = slice[DIGIT];
                count_d  = CW'(count_q + 1'b1);
                if (last_slice) begin
                    // Final slice: publish all results together with done.
                    state_d = DONE;
                    count_d = '0;
                    diff_d  = res_d;
                    b_out_d = slice[DIGIT];
                    ovf_d   = (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
                end
            end
            default: begin
                // IDLE and DONE both accept a new request, so DONE chains
                // straight into RUN for back-to-back operation.
                state_d = IDLE;
                if (start) begin
                    state_d  = RUN;
                    a_d      = a;
                    b_d      = b;
                    res_d    = '0;
                    borrow_d = b_in;
                    count_d  = '0;
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
                end
            end
        endcase
    end

    // State and datapath registers with asynchronous abort to the reset state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand and result registers are reset too, because a
            // mid-operation reset must also clear the published outputs.
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            count_q  <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            b_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            count_q  <= count_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            b_out_q  <= b_out_d;
            ovf_q    <= ovf_d;
        end
    end

    // Handshake outputs decode straight from the state register.
    always_comb begin
        busy  = (state_q == RUN);
        done  = (state_q == DONE);
        diff  = diff_q;
        b_out = b_out_q;
        ovf   = ovf_q;
    end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb_serial_ripple_subtractor
// Scoreboard bench: each accepted request pushes its expected result and the
// cycle its done must appear; an independent monitor pops and compares on done.
module tb_serial_ripple_subtractor;

    localparam int WIDTH = 32;
    localparam int DIGIT = 4;
    localparam int N     = WIDTH / DIGIT;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             b_out;
        logic             ovf;
        int               cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             b_in = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             ovf;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    serial_ripple_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("diff",      64'(diff),  64'(e.diff));
                check("b_out",     64'(b_out), 64'(e.b_out));
                check("ovf",       64'(ovf),   64'(e.ovf));
                check("done_cycle", 64'(cyc),  64'(e.cyc));
            end
        end
    end

    // Issue one request once the DUT can take it; record the expected result.
    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic tbin, input logic [WIDTH-1:0] e_diff,
                         input logic e_bout, input logic e_ovf, input bit hold,
                         output int acc);
        bit   ok = 0;
        exp_t e;
        acc = -1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (!busy) begin
                a     = ta;
                b     = tb_v;
                b_in  = tbin;
                start = 1'b1;
                ok    = 1;
            end
        end
        if (!ok) begin
            check("accept_timeout", 64'd0, 64'd1);
            start = 1'b0;
        end else begin
            acc    = cyc + 1;
            e.diff  = e_diff;
            e.b_out = e_bout;
            e.ovf   = e_ovf;
            e.cyc   = acc + N;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (!hold) start = 1'b0;
        end
    endtask

    initial begin
        int acc;
        int prev_acc;
        logic [WIDTH-1:0] ra, rb, rd;
        logic             rbin, rbo, rov;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_done",  64'(done),  64'd0);
        check("rst_diff",  64'(diff),  64'd0);
        check("rst_b_out", 64'(b_out), 64'd0);
        check("rst_ovf",   64'(ovf),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: basic op, busy exactly N cycles then low on the done edge.
        issue(32'd10, 32'd3, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0, acc);
        for (int i = 0; i < N; i++) begin
            check("busy_high", 64'(busy), 64'd1);
            @(posedge clk);
            #1;
        end
        check("busy_low_at_done", 64'(busy), 64'd0);
        check("done_at_k_plus_n", 64'(done), 64'd1);
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(done), 64'd0);

        // 2-3: wrap, borrow and signed overflow corners.
        issue(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, acc);
        issue(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, acc);
        issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, acc);
        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, acc);

        // 4: borrow-in drives the result negative; a start mid-run is ignored.
        issue(32'd5, 32'd5, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, acc);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a     = 32'd1;
        b     = 32'd1;
        b_in  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        check("held_result", 64'(diff), 64'hFFFF_FFFF);
        repeat (3) @(posedge clk);
        #1;
        check("no_extra_busy", 64'(busy), 64'd0);

        // 5: asynchronous abort mid-operation, then a clean op.
        issue(32'd100, 32'd1, 1'b0, 32'd99, 1'b0, 1'b0, 1'b0, acc);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_busy",  64'(busy),  64'd0);
        check("abort_done",  64'(done),  64'd0);
        check("abort_diff",  64'(diff),  64'd0);
        check("abort_b_out", 64'(b_out), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 4) @(posedge clk);
        issue(32'h1234_5678, 32'h0123_4567, 1'b1, 32'h1111_1110, 1'b0, 1'b0, 1'b0, acc);

        // 6: back-to-back with start held high, reference-model expectations.
        prev_acc = -1;
        for (int i = 0; i < 1000; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rbin = 1'($urandom_range(0, 1));
            if (i % 50 == 0) rb = ra;
            rd   = ra - rb - {{(WIDTH-1){1'b0}}, rbin};
            rbo  = ({1'b0, ra} < ({1'b0, rb} + {{WIDTH{1'b0}}, rbin}));
            rov  = (ra[WIDTH-1] != rb[WIDTH-1]) && (rd[WIDTH-1] != ra[WIDTH-1]);
            issue(ra, rb, rbin, rd, rbo, rov, 1'b1, acc);
            if (prev_acc >= 0 && (i % 100 == 1))
                check("b2b_period", 64'(acc - prev_acc), 64'(N + 1));
            prev_acc = acc;
        end
        start = 1'b0;

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 4 * N && sb.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
